// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler: state encoding,
// register-index width and the default event-counter width.
package issue_scheduler_pkg;

  localparam int REG_IDX_W     = 5;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPLIT   = 2'd1,
    ST_LU_WAIT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/issue_scheduler_hazard_cmp.sv
// Compares one destination register against the two sources of an issue
// slot. A source only counts when it is actually read, and x0 never matches.
module hazard_cmp
  import issue_scheduler_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  input  logic                 i_use_rs1,
  input  logic                 i_use_rs2,
  output logic                 o_match
);

  logic w_rd_nonzero;
  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_rd_nonzero = (i_rd != '0);
  assign w_hit_rs1    = i_use_rs1 & (i_rs1 == i_rd);
  assign w_hit_rs2    = i_use_rs2 & (i_rs2 == i_rd);
  assign o_match      = w_rd_nonzero & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: splits hazardous issue pairs into two single-issue
// cycles and inserts a one-cycle bubble for load-use hazards.
// Optional feature macro: LOAD_USE_ENABLE_EN enables load-use detection,
// the LU_WAIT state and the lu_cnt_o counter.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
)
(
  input  logic                 clock_i,
  input  logic                 rst_ni,
  input  logic                 advance_i,
  input  logic                 valid0_i,
  input  logic                 valid1_i,
  input  logic [REG_IDX_W-1:0] rs1_0_i,
  input  logic [REG_IDX_W-1:0] rs2_0_i,
  input  logic [REG_IDX_W-1:0] rd_0_i,
  input  logic [REG_IDX_W-1:0] rs1_1_i,
  input  logic [REG_IDX_W-1:0] rs2_1_i,
  input  logic [REG_IDX_W-1:0] rd_1_i,
  input  logic                 use_rs1_0_i,
  input  logic                 use_rs2_0_i,
  input  logic                 use_rs1_1_i,
  input  logic                 use_rs2_1_i,
  input  logic                 regwrite0_i,
  input  logic                 regwrite1_i,
  input  logic                 mem0_i,
  input  logic                 mem1_i,
  input  logic                 branch0_i,
  input  logic                 ex_load0_i,
  input  logic                 ex_load1_i,
  input  logic [REG_IDX_W-1:0] ex_rd0_i,
  input  logic [REG_IDX_W-1:0] ex_rd1_i,
  output logic                 issue0_special_stall_o,
  output logic                 issue1_special_stall_o,
  output logic                 split_active_o,
  output logic [CNT_W-1:0]     split_cnt_o,
  output logic [CNT_W-1:0]     lu_cnt_o
);

  sched_state_e r_state;
  sched_state_e w_state_next;

  logic w_raw_match;
  logic w_raw01;
  logic w_waw01;
  logic w_struct;
  logic w_ctl;
  logic w_split_need;
  logic w_lu;
  logic w_stall0;
  logic w_stall1;
  logic w_split_inc;
  logic w_lu_inc;

  logic [CNT_W-1:0] r_split_cnt;

  // Intra-pair hazards: slot 1 must not issue alongside slot 0.
  hazard_cmp u_raw01 (
    .i_rd      (rd_0_i),
    .i_rs1     (rs1_1_i),
    .i_rs2     (rs2_1_i),
    .i_use_rs1 (use_rs1_1_i),
    .i_use_rs2 (use_rs2_1_i),
    .o_match   (w_raw_match)
  );

  assign w_raw01      = valid1_i & regwrite0_i & w_raw_match;
  assign w_waw01      = valid0_i & valid1_i & regwrite0_i & regwrite1_i &
                        (rd_0_i == rd_1_i) & (rd_0_i != '0);
  assign w_struct     = valid0_i & valid1_i & mem0_i & mem1_i;
  assign w_ctl        = valid0_i & branch0_i & valid1_i;
  assign w_split_need = w_raw01 | w_waw01 | w_struct | w_ctl;

`ifdef LOAD_USE_ENABLE_EN
  logic w_e0s0;
  logic w_e0s1;
  logic w_e1s0;
  logic w_e1s1;
  logic [CNT_W-1:0] r_lu_cnt;

  // Each execute-stage load destination is checked against both issue slots.
  hazard_cmp u_lu_e0s0 (
    .i_rd(ex_rd0_i), .i_rs1(rs1_0_i), .i_rs2(rs2_0_i),
    .i_use_rs1(use_rs1_0_i), .i_use_rs2(use_rs2_0_i), .o_match(w_e0s0)
  );
  hazard_cmp u_lu_e0s1 (
    .i_rd(ex_rd0_i), .i_rs1(rs1_1_i), .i_rs2(rs2_1_i),
    .i_use_rs1(use_rs1_1_i), .i_use_rs2(use_rs2_1_i), .o_match(w_e0s1)
  );
  hazard_cmp u_lu_e1s0 (
    .i_rd(ex_rd1_i), .i_rs1(rs1_0_i), .i_rs2(rs2_0_i),
    .i_use_rs1(use_rs1_0_i), .i_use_rs2(use_rs2_0_i), .o_match(w_e1s0)
  );
  hazard_cmp u_lu_e1s1 (
    .i_rd(ex_rd1_i), .i_rs1(rs1_1_i), .i_rs2(rs2_1_i),
    .i_use_rs1(use_rs1_1_i), .i_use_rs2(use_rs2_1_i), .o_match(w_e1s1)
  );

  assign w_lu = (ex_load0_i & ((valid0_i & w_e0s0) | (valid1_i & w_e0s1))) |
                (ex_load1_i & ((valid0_i & w_e1s0) | (valid1_i & w_e1s1)));

  // Saturating count of load-use bubbles inserted.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lu_cnt <= '0;
    end else if (w_lu_inc && (r_lu_cnt != '1)) begin
      r_lu_cnt <= r_lu_cnt + CNT_W'(1);
    end
  end

  assign lu_cnt_o = r_lu_cnt;
`else
  logic w_unused_lu;

  assign w_unused_lu = ^{ex_load0_i, ex_load1_i, ex_rd0_i, ex_rd1_i, w_lu_inc};
  assign w_lu        = 1'b0;
  assign lu_cnt_o    = '0;
`endif

  // State register; only ever leaves a state on an advance cycle.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and stall decode; load-use takes priority over a split.
  always_comb begin
    w_state_next = r_state;
    w_stall0     = 1'b0;
    w_stall1     = 1'b0;
    w_split_inc  = 1'b0;
    w_lu_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_lu) begin
          w_stall0 = 1'b1;
          w_stall1 = 1'b1;
          if (advance_i) begin
            w_state_next = ST_LU_WAIT;
            w_lu_inc     = 1'b1;
          end
        end else if (w_split_need) begin
          w_stall1 = 1'b1;
          if (advance_i) begin
            w_state_next = ST_SPLIT;
            w_split_inc  = 1'b1;
          end
        end
      end
      ST_SPLIT, ST_LU_WAIT: begin
        if (advance_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Saturating count of pairs that were split.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_split_cnt <= '0;
    end else if (w_split_inc && (r_split_cnt != '1)) begin
      r_split_cnt <= r_split_cnt + CNT_W'(1);
    end
  end

  // Stalls are forced low while reset is held, regardless of the inputs.
  assign issue0_special_stall_o = rst_ni & w_stall0;
  assign issue1_special_stall_o = rst_ni & w_stall1;
  assign split_active_o         = (r_state == ST_SPLIT);
  assign split_cnt_o            = r_split_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler. Counters are narrowed to 4 bits
// so saturation is reachable quickly. Honours LOAD_USE_ENABLE_EN.
module tb_issue_scheduler;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
`ifdef LOAD_USE_ENABLE_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic advance, valid0, valid1;
  logic [4:0] rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1, ex_rd0, ex_rd1;
  logic use_rs1_0, use_rs2_0, use_rs1_1, use_rs2_1;
  logic regwrite0, regwrite1, mem0, mem1, branch0, ex_load0, ex_load1;
  logic stall0, stall1, splitActive;
  logic [CW-1:0] splitCnt, luCnt;

  int total = 0;
  int bad = 0;

  // Reference model: number of owed extra cycles and why (0 none, 1 split, 2 load-use)
  int pend = 0;
  int mSplit = 0;
  int mLu = 0;

  issue_scheduler #(.CNT_W(CW)) dut (
    .clock_i(clock), .rst_ni(rst_n), .advance_i(advance),
    .valid0_i(valid0), .valid1_i(valid1),
    .rs1_0_i(rs1_0), .rs2_0_i(rs2_0), .rd_0_i(rd_0),
    .rs1_1_i(rs1_1), .rs2_1_i(rs2_1), .rd_1_i(rd_1),
    .use_rs1_0_i(use_rs1_0), .use_rs2_0_i(use_rs2_0),
    .use_rs1_1_i(use_rs1_1), .use_rs2_1_i(use_rs2_1),
    .regwrite0_i(regwrite0), .regwrite1_i(regwrite1),
    .mem0_i(mem0), .mem1_i(mem1), .branch0_i(branch0),
    .ex_load0_i(ex_load0), .ex_load1_i(ex_load1),
    .ex_rd0_i(ex_rd0), .ex_rd1_i(ex_rd1),
    .issue0_special_stall_o(stall0), .issue1_special_stall_o(stall1),
    .split_active_o(splitActive), .split_cnt_o(splitCnt), .lu_cnt_o(luCnt)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // True when a valid slot genuinely reads register r (x0 excluded)
  function automatic bit readsReg(bit v, bit u1, bit u2, logic [4:0] s1, logic [4:0] s2, logic [4:0] r);
    return v && (r != 0) && ((u1 && s1 == r) || (u2 && s2 == r));
  endfunction

  task automatic clearInputs();
    advance = 1; valid0 = 0; valid1 = 0;
    rs1_0 = 0; rs2_0 = 0; rd_0 = 0; rs1_1 = 0; rs2_1 = 0; rd_1 = 0;
    use_rs1_0 = 0; use_rs2_0 = 0; use_rs1_1 = 0; use_rs2_1 = 0;
    regwrite0 = 0; regwrite1 = 0; mem0 = 0; mem1 = 0; branch0 = 0;
    ex_load0 = 0; ex_load1 = 0; ex_rd0 = 0; ex_rd1 = 0;
  endtask

  task automatic applyStimulus();
    advance   = ($urandom_range(0, 3) != 0);
    valid0    = ($urandom_range(0, 3) != 0);
    valid1    = ($urandom_range(0, 3) != 0);
    rs1_0 = 5'($urandom_range(0, 3)); rs2_0 = 5'($urandom_range(0, 3));
    rd_0  = 5'($urandom_range(0, 3)); rs1_1 = 5'($urandom_range(0, 3));
    rs2_1 = 5'($urandom_range(0, 3)); rd_1  = 5'($urandom_range(0, 3));
    use_rs1_0 = 1'($urandom); use_rs2_0 = 1'($urandom);
    use_rs1_1 = 1'($urandom); use_rs2_1 = 1'($urandom);
    regwrite0 = 1'($urandom); regwrite1 = 1'($urandom);
    mem0      = ($urandom_range(0, 2) == 0);
    mem1      = ($urandom_range(0, 2) == 0);
    branch0   = ($urandom_range(0, 3) == 0);
    ex_load0  = ($urandom_range(0, 2) == 0);
    ex_load1  = ($urandom_range(0, 2) == 0);
    ex_rd0 = 5'($urandom_range(0, 3)); ex_rd1 = 5'($urandom_range(0, 3));
  endtask

  // Called just after a falling edge with inputs set; checks, then clocks the model
  task automatic stepCycle();
    bit raw, waw, strc, ctl, need, lu, e0, e1;
    bit expS0, expS1;
    int nextPend, nextSplit, nextLu;
    #1;
    raw  = valid1 && regwrite0 && readsReg(1'b1, use_rs1_1, use_rs2_1, rs1_1, rs2_1, rd_0);
    waw  = valid0 && valid1 && regwrite0 && regwrite1 && rd_0 == rd_1 && rd_0 != 0;
    strc = valid0 && valid1 && mem0 && mem1;
    ctl  = valid0 && branch0 && valid1;
    need = raw || waw || strc || ctl;
    e0 = ex_load0 && (readsReg(valid0, use_rs1_0, use_rs2_0, rs1_0, rs2_0, ex_rd0) ||
                      readsReg(valid1, use_rs1_1, use_rs2_1, rs1_1, rs2_1, ex_rd0));
    e1 = ex_load1 && (readsReg(valid0, use_rs1_0, use_rs2_0, rs1_0, rs2_0, ex_rd1) ||
                      readsReg(valid1, use_rs1_1, use_rs2_1, rs1_1, rs2_1, ex_rd1));
    lu = LU_EN && (e0 || e1);
    nextPend = pend; nextSplit = mSplit; nextLu = mLu;
    if (!rst_n) begin
      pend = 0; mSplit = 0; mLu = 0;
      expS0 = 0; expS1 = 0;
      nextPend = 0; nextSplit = 0; nextLu = 0;
    end else if (pend != 0) begin
      expS0 = 0; expS1 = 0;
      if (advance) nextPend = 0;
    end else begin
      expS0 = lu;
      expS1 = lu || need;
      if (advance && lu) begin
        nextPend = 2;
        nextLu = (mLu == SAT) ? SAT : mLu + 1;
      end else if (advance && need) begin
        nextPend = 1;
        nextSplit = (mSplit == SAT) ? SAT : mSplit + 1;
      end
    end
    checkOutput("stall0", 32'(stall0), 32'(expS0));
    checkOutput("stall1", 32'(stall1), 32'(expS1));
    checkOutput("split_active", 32'(splitActive), 32'(pend == 1));
    checkOutput("split_cnt", 32'(splitCnt), 32'(mSplit));
    checkOutput("lu_cnt", 32'(luCnt), 32'(mLu));
    @(posedge clock);
    pend = nextPend; mSplit = nextSplit; mLu = nextLu;
    @(negedge clock);
  endtask

  task automatic setRawPair();
    clearInputs();
    valid0 = 1; valid1 = 1; regwrite0 = 1; rd_0 = 5; rs1_1 = 5; use_rs1_1 = 1;
  endtask

  initial begin
    clearInputs();
    rst_n = 0;
    @(negedge clock);
    stepCycle();
    checkOutput("reset_stall1", 32'(stall1), 32'd0);
    rst_n = 1;
    stepCycle();

    // Independent pair
    clearInputs();
    valid0 = 1; valid1 = 1; regwrite0 = 1; regwrite1 = 1; rd_0 = 1; rd_1 = 2;
    rs1_0 = 3; rs1_1 = 4; use_rs1_0 = 1; use_rs1_1 = 1;
    stepCycle();
    stepCycle();

    // RAW pair splits, then returns to IDLE
    setRawPair();
    stepCycle();
    checkOutput("raw_in_split", 32'(splitActive), 32'd1);
    clearInputs(); valid1 = 1;
    stepCycle();
    stepCycle();
    checkOutput("raw_split_cnt", 32'(splitCnt), 32'd1);

    // RAW on x0 never splits
    clearInputs();
    valid0 = 1; valid1 = 1; regwrite0 = 1; rd_0 = 0; rs2_1 = 0; use_rs2_1 = 1;
    stepCycle();

    // Load-use on x7 through slot 1 rs2
    clearInputs();
    valid1 = 1; ex_load0 = 1; ex_rd0 = 7; rs2_1 = 7; use_rs2_1 = 1;
    stepCycle();
    clearInputs();
    stepCycle();
    stepCycle();

    // Load-use combined with a split pair: load-use first, split afterwards
    setRawPair();
    ex_load1 = 1; ex_rd1 = 5; rs1_0 = 5; use_rs1_0 = 1;
    stepCycle();
    ex_load1 = 0;
    stepCycle();
    stepCycle();
    clearInputs();
    stepCycle();

    // Two memory ops held without advance, then advanced
    clearInputs();
    valid0 = 1; valid1 = 1; mem0 = 1; mem1 = 1; advance = 0;
    repeat (3) stepCycle();
    advance = 1;
    stepCycle();
    checkOutput("mem_split_active", 32'(splitActive), 32'd1);
    clearInputs();
    stepCycle();

    // Saturate the split counter
    for (int i = 0; i < SAT + 4; i++) begin
      setRawPair();
      stepCycle();
      clearInputs();
      stepCycle();
    end
    checkOutput("split_saturated", 32'(splitCnt), 32'(SAT));

    // Reset while in SPLIT with hazard inputs still present
    setRawPair();
    stepCycle();
    rst_n = 0;
    stepCycle();
    checkOutput("rst_split_active", 32'(splitActive), 32'd0);
    checkOutput("rst_split_cnt", 32'(splitCnt), 32'd0);
    rst_n = 1;
    stepCycle();

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      rst_n = (i != 1500);
      stepCycle();
    end
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
